// File: rtl/iopad_ctrl.sv
// Register-programmed IO pad bank controller.
// Adds a dead-time turnaround on output-enable direction changes, and synchronises and glitch-filters the pad inputs.
module iopad_ctrl #(
    parameter int WIDTH = 8,
    parameter int TURN  = 2,
    parameter int FILT  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [WIDTH-1:0] cfg_wdata,
    output logic [WIDTH-1:0] cfg_rdata,
    output logic             irq,
    output logic [WIDTH-1:0] pad_c2p,
    output logic [WIDTH-1:0] pad_c2p_en,
    input  logic [WIDTH-1:0] pad_p2c
);

    localparam logic [3:0] TURN_LD   = 4'(TURN);
    localparam logic [3:0] FILT_LAST = 4'(FILT - 1);

    logic [WIDTH-1:0]      dir_q, in_q, rise_en_q, fall_en_q, irq_stat_q;
    logic [WIDTH-1:0]      s1_q, s2_q;
    logic [WIDTH-1:0][3:0] turn_cnt_q, turn_cnt_nxt;
    logic [WIDTH-1:0][3:0] filt_cnt_q, filt_cnt_nxt;
    logic [WIDTH-1:0]      dir_nxt, dir_chg, en_nxt, in_nxt;
    logic [WIDTH-1:0]      irq_set, irq_clr, stat_nxt, rd_mux;
    logic                  wr_dir, wr_out, wr_rise, wr_fall, wr_stat;

    assign wr_dir  = cfg_we && (cfg_addr == 3'd0);
    assign wr_out  = cfg_we && (cfg_addr == 3'd1);
    assign wr_rise = cfg_we && (cfg_addr == 3'd3);
    assign wr_fall = cfg_we && (cfg_addr == 3'd4);
    assign wr_stat = cfg_we && (cfg_addr == 3'd5);

    // Turnaround: any direction change drops the enable and restarts the dead-time down-counter.
    always_comb begin
        dir_nxt      = wr_dir ? cfg_wdata : dir_q;
        dir_chg      = dir_nxt ^ dir_q;
        en_nxt       = pad_c2p_en;
        turn_cnt_nxt = turn_cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (dir_chg[i]) begin
                en_nxt[i]       = (TURN == 0) ? dir_nxt[i] : 1'b0;
                turn_cnt_nxt[i] = TURN_LD;
            end else if (turn_cnt_q[i] != 4'd0) begin
                turn_cnt_nxt[i] = turn_cnt_q[i] - 4'd1;
                if (turn_cnt_q[i] == 4'd1) begin
                    en_nxt[i] = dir_q[i];
                end
            end
        end
    end

    always_comb begin
        in_nxt       = in_q;
        filt_cnt_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (s2_q[i] != in_q[i]) begin
                if (filt_cnt_q[i] == FILT_LAST) begin
                    in_nxt[i] = s2_q[i];
                end else begin
                    filt_cnt_nxt[i] = filt_cnt_q[i] + 4'd1;
                end
            end
        end
    end

    // A new edge event beats a simultaneous W1C on the same bit.
    assign irq_set  = (in_nxt & ~in_q & rise_en_q) | (~in_nxt & in_q & fall_en_q);
    assign irq_clr  = wr_stat ? cfg_wdata : '0;
    assign stat_nxt = (irq_stat_q & ~irq_clr) | irq_set;

    always_comb begin
        rd_mux = '0;
        case (cfg_addr)
            3'd0:    rd_mux = dir_q;
            3'd1:    rd_mux = pad_c2p;
            3'd2:    rd_mux = in_q;
            3'd3:    rd_mux = rise_en_q;
            3'd4:    rd_mux = fall_en_q;
            3'd5:    rd_mux = irq_stat_q;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dir_q      <= '0;
            pad_c2p    <= '0;
            pad_c2p_en <= '0;
            in_q       <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            irq_stat_q <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            turn_cnt_q <= '0;
            filt_cnt_q <= '0;
            cfg_rdata  <= '0;
            irq        <= 1'b0;
        end else begin
            dir_q      <= dir_nxt;
            pad_c2p_en <= en_nxt;
            turn_cnt_q <= turn_cnt_nxt;
            if (wr_out)  pad_c2p   <= cfg_wdata;
            if (wr_rise) rise_en_q <= cfg_wdata;
            if (wr_fall) fall_en_q <= cfg_wdata;
            s1_q       <= pad_p2c;
            s2_q       <= s1_q;
            in_q       <= in_nxt;
            filt_cnt_q <= filt_cnt_nxt;
            irq_stat_q <= stat_nxt;
            irq        <= |irq_stat_q;
            cfg_rdata  <= rd_mux;
        end
    end

endmodule

// File: tb/tb_iopad_ctrl.sv
// Bench for iopad_ctrl: a per-edge behavioural model checked every cycle, plus directed literal checks.
module tb_iopad_ctrl;

    localparam int W    = 8;
    localparam int TURN = 2;
    localparam int FILT = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cfg_we;
    logic [2:0]   cfg_addr;
    logic [W-1:0] cfg_wdata;
    logic [W-1:0] cfg_rdata;
    logic         irq;
    logic [W-1:0] pad_c2p;
    logic [W-1:0] pad_c2p_en;
    logic [W-1:0] pad_p2c;

    iopad_ctrl #(.WIDTH(W), .TURN(TURN), .FILT(FILT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .irq        (irq),
        .pad_c2p    (pad_c2p),
        .pad_c2p_en (pad_c2p_en),
        .pad_p2c    (pad_p2c)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the enable is the direction once TURN edges have passed since that bit last changed;
    // IN flips once the last FILT synchronised samples all disagree with it.
    int           cyc = 0;
    bit           m_valid = 1'b0;
    int           last_chg [W];
    logic [W-1:0] m_dir, m_out, m_in, m_rise, m_fall, m_stat, m_rdata, m_s1, m_s2;
    logic         m_irq;
    logic [W-1:0] hist [$];
    logic [W-1:0] nin, clr;
    bit           flip;

    function automatic logic [W-1:0] exp_en();
        logic [W-1:0] e;
        for (int i = 0; i < W; i++) e[i] = (cyc >= last_chg[i] + TURN) ? m_dir[i] : 1'b0;
        return e;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_dir = '0; m_out = '0; m_in = '0; m_rise = '0; m_fall = '0;
            m_stat = '0; m_rdata = '0; m_s1 = '0; m_s2 = '0; m_irq = 1'b0;
            hist.delete();
            for (int i = 0; i < W; i++) last_chg[i] = cyc - 100;
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > FILT) void'(hist.pop_front());
            nin = m_in;
            if (hist.size() == FILT) begin
                for (int i = 0; i < W; i++) begin
                    flip = 1'b1;
                    foreach (hist[j]) if (hist[j][i] == m_in[i]) flip = 1'b0;
                    if (flip) nin[i] = ~m_in[i];
                end
            end
            case (cfg_addr)
                3'd0: m_rdata = m_dir;
                3'd1: m_rdata = m_out;
                3'd2: m_rdata = m_in;
                3'd3: m_rdata = m_rise;
                3'd4: m_rdata = m_fall;
                3'd5: m_rdata = m_stat;
                default: m_rdata = '0;
            endcase
            clr    = (cfg_we && cfg_addr == 3'd5) ? cfg_wdata : '0;
            m_irq  = |m_stat;
            m_stat = (m_stat & ~clr) | (nin & ~m_in & m_rise) | (~nin & m_in & m_fall);
            m_in   = nin;
            if (cfg_we) begin
                case (cfg_addr)
                    3'd0: begin
                        for (int i = 0; i < W; i++) if (cfg_wdata[i] != m_dir[i]) last_chg[i] = cyc;
                        m_dir = cfg_wdata;
                    end
                    3'd1: m_out  = cfg_wdata;
                    3'd3: m_rise = cfg_wdata;
                    3'd4: m_fall = cfg_wdata;
                    default: ;
                endcase
            end
            m_s2 = m_s1;
            m_s1 = pad_p2c;
        end
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_c2p",   pad_c2p,    m_out);
            chk("model_c2pen", pad_c2p_en, exp_en());
            chk("model_rdata", cfg_rdata,  m_rdata);
            chk("model_irq",   irq,        m_irq);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_wdata = '0; pad_p2c = '0;
        tick(2);
        rst_n = 1'b1;
        chk("rst_c2p", pad_c2p, 8'h00);
        chk("rst_en",  pad_c2p_en, 8'h00);
        chk("rst_irq", irq, 1'b0);
        for (int a = 0; a < 8; a++) begin
            cfg_addr = 3'(a);
            tick(1);
            chk($sformatf("rst_read%0d", a), cfg_rdata, 8'h00);
        end

        // Turnaround, input to output
        wr(3'd1, 8'hA5);
        chk("c2p_same_edge", pad_c2p, 8'hA5);
        wr(3'd0, 8'hFF);
        chk("en_k", pad_c2p_en, 8'h00);
        tick(1);
        chk("en_k1", pad_c2p_en, 8'h00);
        tick(1);
        chk("en_k2", pad_c2p_en, 8'hFF);
        chk("model_en_k2", exp_en(), 8'hFF);

        // Upper nibble goes to input; lower nibble untouched
        wr(3'd0, 8'h0F);
        chk("en_m", pad_c2p_en, 8'h0F);
        wr(3'd0, 8'h0F);
        chk("en_rewrite", pad_c2p_en, 8'h0F);
        tick(2);
        chk("en_m3", pad_c2p_en, 8'h0F);

        // Turnaround restart on bit 0
        wr(3'd0, 8'h00);
        tick(3);
        wr(3'd0, 8'h01);
        chk("rs_a", pad_c2p_en[0], 1'b0);
        wr(3'd0, 8'h00);
        chk("rs_a1", pad_c2p_en[0], 1'b0);
        wr(3'd0, 8'h01);
        chk("rs_a2", pad_c2p_en[0], 1'b0);
        tick(1);
        chk("rs_a3", pad_c2p_en[0], 1'b0);
        tick(1);
        chk("rs_a4", pad_c2p_en[0], 1'b1);

        // Glitch filter
        cfg_addr = 3'd2;
        pad_p2c = 8'h08;
        tick(2);
        pad_p2c = 8'h00;
        tick(8);
        chk("glitch_in", cfg_rdata, 8'h00);
        pad_p2c = 8'h08;
        tick(5);
        chk("filt_e4_rd", cfg_rdata, 8'h00);
        chk("model_in_e4", m_in, 8'h08);
        pad_p2c = 8'h00;
        tick(1);
        chk("filt_e5_rd", cfg_rdata, 8'h08);
        tick(8);

        // Rising-edge interrupt only
        wr(3'd3, 8'h08);
        wr(3'd4, 8'h00);
        cfg_addr = 3'd5;
        pad_p2c = 8'h08;
        tick(5);
        chk("irq_e4", irq, 1'b0);
        tick(1);
        chk("irq_e5", irq, 1'b1);
        chk("stat_e5", cfg_rdata, 8'h08);
        pad_p2c = 8'h00;
        tick(8);
        chk("stat_after_fall", cfg_rdata, 8'h08);

        // W1C colliding with a new rise: set wins
        pad_p2c = 8'h08;
        tick(4);
        wr(3'd5, 8'h08);
        tick(1);
        chk("stat_collide", cfg_rdata, 8'h08);
        pad_p2c = 8'h00;
        tick(8);

        // W1C alone
        wr(3'd5, 8'h08);
        chk("irq_w", irq, 1'b1);
        tick(1);
        chk("irq_w1", irq, 1'b0);
        chk("stat_w1", cfg_rdata, 8'h00);

        // Reset during turnaround and partial filter count
        wr(3'd3, 8'hFF);
        pad_p2c = 8'h20;
        wr(3'd0, 8'hF0);
        tick(1);
        rst_n = 1'b0;
        tick(1);
        chk("mid_rst_en",  pad_c2p_en, 8'h00);
        chk("mid_rst_c2p", pad_c2p, 8'h00);
        pad_p2c = 8'h00;
        rst_n = 1'b1;
        cfg_addr = 3'd5;
        tick(10);
        chk("post_rst_irq",  irq, 1'b0);
        chk("post_rst_stat", cfg_rdata, 8'h00);
        cfg_addr = 3'd0;
        tick(1);
        chk("post_rst_dir", cfg_rdata, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/iopad_ctrl.md
# iopad_ctrl

Register-programmed controller for a bank of bidirectional IO pads (IOPadInOut-style cells with `c2p`, `c2p_en`, `p2c`). It sits between the core register bus and the pad ring. On the output side it enforces a dead-time turnaround on every direction change, so core and pad never drive the pin at the same time. On the input side it synchronises and glitch-filters `p2c`, then raises edge-triggered interrupts.

## Interface
Parameters:
- `WIDTH`, default 8: number of pads controlled (1..32).
- `TURN`, default 2: turnaround cycles with `c2p_en` forced low after a direction change (0..15).
- `FILT`, default 3: cycles a synchronised input must be stable before it is accepted (1..15).

Ports:
- `clk`  in  1: single clock. All flops are rising-edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `cfg_we`  in  1: write strobe, sampled at the clock edge.
- `cfg_addr`  in  3: register address (write and read).
- `cfg_wdata`  in  WIDTH: write data.
- `cfg_rdata`  out  WIDTH: registered read data.
- `irq`  out  1: registered OR of `IRQ_STAT`.
- `pad_c2p`  out  WIDTH: per-pad core-to-pad data.
- `pad_c2p_en`  out  WIDTH: per-pad output enable (1 = drive).
- `pad_p2c`  in  WIDTH: per-pad pad-to-core data, asynchronous.

## Operation
Register map (`cfg_addr`):
- 0 `DIR`: 1 = output.
- 1 `OUT`: drive values.
- 2 `IN`: read-only filtered inputs. Writes are ignored.
- 3 `RISE_EN`: per-bit rising-edge interrupt enable.
- 4 `FALL_EN`: per-bit falling-edge interrupt enable.
- 5 `IRQ_STAT`: write-1-to-clear.
- 6, 7: read as 0, writes ignored.

Reset values: every register, `cfg_rdata`, `irq`, `pad_c2p`, `pad_c2p_en`, synchroniser, filter and turnaround state are 0. All pads therefore start as undriven inputs.

Output path:
- `pad_c2p[i]` = `OUT[i]`, registered.
- Each bit has a turnaround counter.
- A write to `DIR` that changes bit i has these effects at the write edge:
  - `pad_c2p_en[i]` is cleared.
  - The counter is loaded with `TURN`.
- The counter then decrements once per cycle.
- `pad_c2p_en[i]` is set to `DIR[i]` at the edge where the counter reaches 0.
- `TURN`=0 means `pad_c2p_en` follows `DIR` at the write edge.
- Writing the same `DIR` value has no effect and does not restart an active turnaround.
- A `DIR` change during a turnaround reloads the counter to `TURN`.

Input path, per bit:
- Two-flop synchroniser: `pad_p2c` → `s1` → `s2`.
- The filter counter increments while `s2` ≠ `IN` and clears to 0 when they are equal.
- When `s2` ≠ `IN` and the counter equals `FILT-1`, `IN` ← `s2` and the counter clears.
- Pulses on `s2` shorter than `FILT` cycles never reach `IN`.
- The input path runs regardless of `DIR`, so an output pad reads back its own pin.

Interrupts:
- When `IN[i]` rises and `RISE_EN[i]` = 1, `IRQ_STAT[i]` is set at that same edge.
- When `IN[i]` falls and `FALL_EN[i]` = 1, `IRQ_STAT[i]` is set at that same edge.
- A W1C write clears the written 1 bits. If a set and a clear hit the same bit on the same edge, the set wins.
- Changing an enable does not clear bits that are already set in `IRQ_STAT`.
- `irq` ← |`IRQ_STAT`, registered.

Reset mid-operation: `rst_n` low at an edge immediately zeroes all state, including an in-progress turnaround and filter count. `pad_c2p_en` is 0 from that edge.

## Timing
- Write latency: a register changes at the edge where `cfg_we` = 1. `pad_c2p` changes at that same edge.
- Read latency: `cfg_rdata` is updated every edge from `cfg_addr` and holds the register value from before that edge. Data is valid one cycle after the address is presented.
- Direction timing, for a `DIR` change at edge k:
  - Output-to-input: `pad_c2p_en` is low from edge k.
  - Input-to-output: `pad_c2p_en` is low for cycles k..k+`TURN`-1 and high from edge k+`TURN`.
- Input latency: if `pad_p2c` changes and is first sampled into `s1` at edge e, `IN` updates at edge e+1+`FILT`.
- Interrupt latency: `IRQ_STAT` sets at that same edge e+1+`FILT`, and `irq` asserts at edge e+2+`FILT`.
- W1C timing: `IRQ_STAT` clears at the write edge and `irq` deasserts one edge later, provided no other bit is set.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles, then release. Expect all outputs 0 and register reads 0 at addresses 0..7.
- Turnaround (`TURN`=2):
  - Write `OUT`=0xA5, then `DIR`=0xFF at edge k. Expect `pad_c2p`=0xA5 from edge k, and `pad_c2p_en` 0x00 at k and k+1, then 0xFF from k+2.
  - Write `DIR`=0x0F at edge m. Expect `pad_c2p_en`=0x0F from edge m+2, with bits 7..4 low from edge m.
  - Rewrite `DIR`=0x0F mid-sequence. Expect no change.
- Turnaround restart: write `DIR`=0x01, write `DIR`=0x00 one cycle later, then `DIR`=0x01 again. Expect `pad_c2p_en[0]` never high until 2 full cycles after the last write.
- Glitch filter (`FILT`=3):
  - Pulse `pad_p2c[3]` high for 2 cycles. Expect `IN` to remain 0x00.
  - Hold `pad_p2c[3]` high for 5 cycles. Expect `IN`=0x08 at edge e+4.
- Interrupts:
  - Set `RISE_EN`=0x08 and `FALL_EN`=0x00. Toggle bit 3 high then low. Expect `IRQ_STAT`=0x08 after the rise and no change after the fall. Expect `irq`=1 one edge after `IRQ_STAT` sets.
  - W1C-write 0x08 on the same edge that a new rise arrives. Expect `IRQ_STAT` to stay 0x08.
  - W1C-write 0x08 alone. Expect `IRQ_STAT`=0 and `irq`=0 one edge later.
- Mid-operation reset: assert `rst_n` = 0 during an active turnaround and a partial filter count. Expect all state zeroed at that edge and no spurious `IRQ_STAT` bit after release.
